// File: rtl/irq_controller_pkg.sv
// Shared widths and FSM encoding for the interrupt controller.
package irq_controller_pkg;

    localparam int unsigned N_SRC = 16;
    localparam int unsigned ID_W  = 4;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

endpackage

// File: rtl/irq_controller_encoder.sv
// 16-to-4 priority encoder; the highest set index wins, output is 0 when disabled.
module irq_controller_encoder
    import irq_controller_pkg::*;
(
    input  logic [N_SRC-1:0] w,
    input  logic             en,
    output logic [ID_W-1:0]  y
);

    always_comb begin
        y = '0;
        if (en) begin
            for (int i = 0; i < N_SRC; i++) begin
                if (w[i]) y = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Interrupt front-end: edge/level pending capture, masking, priority select and
// a valid/ack presentation handshake.
module irq_controller
    import irq_controller_pkg::*;
#(
    parameter logic [N_SRC-1:0] TRIG_EDGE = 16'hFFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_in,
    input  logic [N_SRC-1:0] mask,
    input  logic             irq_ack,
    output logic             irq_valid,
    output logic [ID_W-1:0]  irq_id,
    output logic [N_SRC-1:0] pending
);

    state_t           state, state_nxt;
    logic             valid_nxt;
    logic [ID_W-1:0]  id_nxt;
    logic [ID_W-1:0]  enc_id;
    logic [N_SRC-1:0] irq_q;
    logic [N_SRC-1:0] edge_det;
    logic [N_SRC-1:0] ack_clr;
    logic [N_SRC-1:0] masked;
    logic [N_SRC-1:0] pending_nxt;
    logic             any_masked;
    logic             ack_fire;

    assign edge_det   = irq_in & ~irq_q;
    assign masked     = pending & mask;
    assign any_masked = |masked;
    assign ack_fire   = (state == PRESENT) && irq_ack;
    assign ack_clr    = ack_fire ? (N_SRC'(1) << irq_id) : '0;

    // Edge sources: a new edge beats a same-cycle ack clear. Level sources follow the line.
    assign pending_nxt = (TRIG_EDGE & ((pending & ~ack_clr) | edge_det))
                       | (~TRIG_EDGE & irq_in);

    irq_controller_encoder u_encoder (
        .w  (masked),
        .en (any_masked),
        .y  (enc_id)
    );

    // irq_q tracks the line even in reset so a line held high produces no edge afterwards.
    always_ff @(posedge clk) begin
        irq_q <= irq_in;
        if (rst) begin
            state     <= IDLE;
            pending   <= '0;
            irq_valid <= 1'b0;
            irq_id    <= '0;
        end else begin
            state     <= state_nxt;
            pending   <= pending_nxt;
            irq_valid <= valid_nxt;
            irq_id    <= id_nxt;
        end
    end

    // Once presented, the ID is held until acknowledged; no preemption or retraction.
    always_comb begin
        state_nxt = state;
        valid_nxt = irq_valid;
        id_nxt    = irq_id;
        case (state)
            IDLE: begin
                valid_nxt = 1'b0;
                if (any_masked) begin
                    id_nxt    = enc_id;
                    valid_nxt = 1'b1;
                    state_nxt = PRESENT;
                end
            end
            PRESENT: begin
                valid_nxt = 1'b1;
                if (irq_ack) begin
                    valid_nxt = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                valid_nxt = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: one edge-triggered and one level-triggered instance.
module tb_irq_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] irq_in, mask, irq_in_l, mask_l;
    logic        irq_ack, ack_l;
    logic        irq_valid, valid_l;
    logic [3:0]  irq_id, id_l;
    logic [15:0] pending, pending_l;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    irq_controller dut_e (
        .clk(clk), .rst(rst), .irq_in(irq_in), .mask(mask), .irq_ack(irq_ack),
        .irq_valid(irq_valid), .irq_id(irq_id), .pending(pending)
    );

    irq_controller #(.TRIG_EDGE(16'h0000)) dut_l (
        .clk(clk), .rst(rst), .irq_in(irq_in_l), .mask(mask_l), .irq_ack(ack_l),
        .irq_valid(valid_l), .irq_id(id_l), .pending(pending_l)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; irq_in = 16'h0010; mask = 16'hFFFF; irq_ack = 1'b0;
        irq_in_l = 16'h0000; mask_l = 16'h0000; ack_l = 1'b0;
        tick(); tick();
        n_cmp++; if (pending !== 16'h0000) begin n_err++; $display("FAIL reset_pending got=%h exp=0000", pending); end
        n_cmp++; if (irq_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", irq_valid); end
        n_cmp++; if (irq_id !== 4'd0) begin n_err++; $display("FAIL reset_id got=%0d exp=0", irq_id); end
        n_cmp++; if (pending_l !== 16'h0000) begin n_err++; $display("FAIL reset_pending_l got=%h exp=0000", pending_l); end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (pending !== 16'h0000) begin n_err++; $display("FAIL post_reset_pending[%0d] got=%h exp=0000", i, pending); end
            n_cmp++; if (irq_valid !== 1'b0) begin n_err++; $display("FAIL post_reset_valid[%0d] got=%b exp=0", i, irq_valid); end
        end
        irq_in = 16'h0000;
        tick();
    endtask

    task automatic test_single();
        irq_in = 16'h0008;
        tick();
        n_cmp++; if (pending !== 16'h0008) begin n_err++; $display("FAIL single_pending_t0 got=%h exp=0008", pending); end
        n_cmp++; if (irq_valid !== 1'b0) begin n_err++; $display("FAIL single_valid_t0 got=%b exp=0", irq_valid); end
        irq_in = 16'h0000;
        tick();
        n_cmp++; if (irq_valid !== 1'b1) begin n_err++; $display("FAIL single_valid_t1 got=%b exp=1", irq_valid); end
        n_cmp++; if (irq_id !== 4'd3) begin n_err++; $display("FAIL single_id got=%0d exp=3", irq_id); end
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        n_cmp++; if (pending !== 16'h0000) begin n_err++; $display("FAIL single_pending_ack got=%h exp=0000", pending); end
        n_cmp++; if (irq_valid !== 1'b0) begin n_err++; $display("FAIL single_valid_ack got=%b exp=0", irq_valid); end
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        n_cmp++; if (irq_valid !== 1'b0) begin n_err++; $display("FAIL idle_ack_valid got=%b exp=0", irq_valid); end
    endtask

    task automatic test_priority();
        logic [3:0]  exp_id [3];
        logic [15:0] exp_pend [3];
        exp_id = '{4'd15, 4'd7, 4'd0};
        exp_pend = '{16'h0081, 16'h0001, 16'h0000};
        irq_in = 16'h8081;
        tick();
        irq_in = 16'h0000;
        n_cmp++; if (pending !== 16'h8081) begin n_err++; $display("FAIL prio_pending got=%h exp=8081", pending); end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++; if (irq_valid !== 1'b1) begin n_err++; $display("FAIL prio_valid[%0d] got=%b exp=1", k, irq_valid); end
            n_cmp++; if (irq_id !== exp_id[k]) begin n_err++; $display("FAIL prio_id[%0d] got=%0d exp=%0d", k, irq_id, exp_id[k]); end
            irq_ack = 1'b1;
            tick();
            irq_ack = 1'b0;
            n_cmp++; if (irq_valid !== 1'b0) begin n_err++; $display("FAIL prio_gap[%0d] got=%b exp=0", k, irq_valid); end
            n_cmp++; if (pending !== exp_pend[k]) begin n_err++; $display("FAIL prio_pend[%0d] got=%h exp=%h", k, pending, exp_pend[k]); end
        end
        tick();
        n_cmp++; if (irq_valid !== 1'b0) begin n_err++; $display("FAIL prio_drained got=%b exp=0", irq_valid); end
    endtask

    task automatic test_no_preempt();
        irq_in = 16'h0010;
        tick();
        irq_in = 16'h0000;
        tick();
        n_cmp++; if (irq_valid !== 1'b1 || irq_id !== 4'd4) begin n_err++; $display("FAIL preempt_first got=%b/%0d exp=1/4", irq_valid, irq_id); end
        irq_in = 16'h1000;
        tick();
        irq_in = 16'h0000;
        n_cmp++; if (pending !== 16'h1010) begin n_err++; $display("FAIL preempt_pending got=%h exp=1010", pending); end
        n_cmp++; if (irq_valid !== 1'b1 || irq_id !== 4'd4) begin n_err++; $display("FAIL preempt_hold got=%b/%0d exp=1/4", irq_valid, irq_id); end
        mask = 16'h0000;
        tick();
        n_cmp++; if (irq_valid !== 1'b1 || irq_id !== 4'd4) begin n_err++; $display("FAIL preempt_mask_hold got=%b/%0d exp=1/4", irq_valid, irq_id); end
        mask = 16'hFFFF; irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        n_cmp++; if (pending !== 16'h1000) begin n_err++; $display("FAIL preempt_ack_pend got=%h exp=1000", pending); end
        tick();
        n_cmp++; if (irq_valid !== 1'b1 || irq_id !== 4'd12) begin n_err++; $display("FAIL preempt_second got=%b/%0d exp=1/12", irq_valid, irq_id); end
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    task automatic test_same_cycle();
        irq_in = 16'h0020;
        tick();
        irq_in = 16'h0000;
        tick();
        n_cmp++; if (irq_valid !== 1'b1 || irq_id !== 4'd5) begin n_err++; $display("FAIL same_first got=%b/%0d exp=1/5", irq_valid, irq_id); end
        irq_in = 16'h0020; irq_ack = 1'b1;
        tick();
        irq_in = 16'h0000; irq_ack = 1'b0;
        n_cmp++; if (pending !== 16'h0020) begin n_err++; $display("FAIL same_pending got=%h exp=0020", pending); end
        n_cmp++; if (irq_valid !== 1'b0) begin n_err++; $display("FAIL same_gap got=%b exp=0", irq_valid); end
        tick();
        n_cmp++; if (irq_valid !== 1'b1 || irq_id !== 4'd5) begin n_err++; $display("FAIL same_repres got=%b/%0d exp=1/5", irq_valid, irq_id); end
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        n_cmp++; if (pending !== 16'h0000) begin n_err++; $display("FAIL same_cleared got=%h exp=0000", pending); end
    endtask

    task automatic test_masked_pending();
        mask = 16'h0000; irq_in = 16'h0004;
        tick();
        irq_in = 16'h0000;
        n_cmp++; if (pending !== 16'h0004) begin n_err++; $display("FAIL mpend_pending got=%h exp=0004", pending); end
        tick(); tick();
        n_cmp++; if (irq_valid !== 1'b0) begin n_err++; $display("FAIL mpend_blocked got=%b exp=0", irq_valid); end
        mask = 16'hFFFF;
        tick();
        n_cmp++; if (irq_valid !== 1'b1 || irq_id !== 4'd2) begin n_err++; $display("FAIL mpend_unmask got=%b/%0d exp=1/2", irq_valid, irq_id); end
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    task automatic test_level();
        irq_in_l = 16'h0200; mask_l = 16'hFDFF;
        tick();
        n_cmp++; if (pending_l !== 16'h0200) begin n_err++; $display("FAIL level_pending got=%h exp=0200", pending_l); end
        tick();
        n_cmp++; if (valid_l !== 1'b0) begin n_err++; $display("FAIL level_masked got=%b exp=0", valid_l); end
        mask_l = 16'hFFFF;
        tick();
        n_cmp++; if (valid_l !== 1'b1 || id_l !== 4'd9) begin n_err++; $display("FAIL level_unmask got=%b/%0d exp=1/9", valid_l, id_l); end
        ack_l = 1'b1;
        tick();
        ack_l = 1'b0;
        n_cmp++; if (valid_l !== 1'b0 || pending_l !== 16'h0200) begin n_err++; $display("FAIL level_ack got=%b/%h exp=0/0200", valid_l, pending_l); end
        tick();
        n_cmp++; if (valid_l !== 1'b1 || id_l !== 4'd9) begin n_err++; $display("FAIL level_repres got=%b/%0d exp=1/9", valid_l, id_l); end
        irq_in_l = 16'h0000;
        tick();
        n_cmp++; if (pending_l !== 16'h0000 || valid_l !== 1'b1) begin n_err++; $display("FAIL level_drop got=%h/%b exp=0000/1", pending_l, valid_l); end
        ack_l = 1'b1;
        tick();
        ack_l = 1'b0;
        tick(); tick();
        n_cmp++; if (valid_l !== 1'b0 || pending_l !== 16'h0000) begin n_err++; $display("FAIL level_quiet got=%b/%h exp=0/0000", valid_l, pending_l); end
    endtask

    task automatic test_reset_mid();
        irq_in = 16'h0002;
        tick();
        irq_in = 16'h0040;
        tick();
        irq_in = 16'h0000;
        n_cmp++; if (irq_valid !== 1'b1 || irq_id !== 4'd1 || pending !== 16'h0042) begin n_err++; $display("FAIL rmid_setup got=%b/%0d/%h exp=1/1/0042", irq_valid, irq_id, pending); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (irq_valid !== 1'b0 || pending !== 16'h0000) begin n_err++; $display("FAIL rmid_reset got=%b/%h exp=0/0000", irq_valid, pending); end
        tick(); tick();
        n_cmp++; if (irq_valid !== 1'b0) begin n_err++; $display("FAIL rmid_after got=%b exp=0", irq_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_no_preempt();
        test_same_cycle();
        test_masked_pending();
        test_level();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Interrupt front-end for the existing 16-to-4 priority encoder: latches 16 request lines into a pending register, applies a mask, priority-encodes (bit 15 highest), and presents one interrupt ID at a time over a valid/ack handshake.
- Sits between raw peripheral request lines and the consumer (CPU/sequencer) that services and acknowledges interrupts.

Parameters:
- TRIG_EDGE, 16'hFFFF, per-source trigger mode: 1 = rising-edge latched, 0 = level (pending tracks input).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- irq_in  in  16  raw request lines, already synchronous to clk
- mask  in  16  per-source enable, 1 = source may be presented
- irq_ack  in  1  consumer acknowledges the presented ID (sampled only while irq_valid=1)
- irq_valid  out  1  an ID is being presented
- irq_id  out  4  presented source index, stable while irq_valid=1
- pending  out  16  raw pending register (unmasked), for status reads

Behaviour:
- One clock domain; reset is synchronous and active-high (ports clk, rst).
- Reset: pending=0, irq_valid=0, irq_id=0, FSM=IDLE. irq_q (previous-input register) loads irq_in during reset, so a line held high through reset produces no edge afterwards.
- irq_q <= irq_in every cycle; edge[i] = irq_in[i] & ~irq_q[i].
- Edge source (TRIG_EDGE[i]=1): pending[i] set on edge[i]; cleared only by ack of ID i. If set and clear hit the same bit in the same cycle, set wins (no lost edge).
- Level source (TRIG_EDGE[i]=0): pending[i] <= irq_in[i] every cycle; ack has no effect; source must drop the line.
- masked = pending & mask; fed to the encoder with en = |masked; highest set index wins.
- FSM IDLE: if |masked, register encoder output into irq_id, irq_valid <= 1, go PRESENT; else stay, irq_valid=0.
- FSM PRESENT: irq_valid=1, irq_id held. No retraction or preemption: a new higher-priority request, a mask change, or a level source dropping does not change irq_id or irq_valid.
- PRESENT with irq_ack=1: clear pending[irq_id] (edge sources), irq_valid <= 0, go IDLE.
- irq_ack while IDLE is ignored.
- Latency: irq_in rises before edge T0 -> pending set at T0 -> irq_valid=1 after T1 (2 cycles).
- Back-to-back: ack at edge Ta -> irq_valid low for exactly one cycle (after Ta) -> next ID valid after Ta+1 if any masked pending remains.
- Reset asserted mid-PRESENT: all pending requests dropped, irq_valid=0 the cycle after the reset edge.
- Masked pending bits stay pending and become eligible as soon as mask is set.

Decomposition:
- Shared package: N_SRC=16, ID_W=4, FSM state encoding (IDLE=1'b0, PRESENT=1'b1).
- One sub-module: the existing 16-to-4 priority encoder "encoder" (w=masked, en=|masked, y=encoded ID), instantiated unchanged. Edge detect, pending register and FSM stay in irq_controller.

Test Plan:
- Reset with irq_in=16'h0010 held high, then release -> pending stays 16'h0000 for edge mode, irq_valid stays 0.
- mask=16'hFFFF, pulse irq_in[3] for one cycle -> pending=16'h0008 after T0, irq_valid=1 and irq_id=3 after T1; ack -> pending=16'h0000, irq_valid=0.
- Pulse bits 0, 7 and 15 in the same cycle -> presented in order 15, 7, 0, each after ack, with exactly one idle cycle between valids.
- While presenting ID 4, pulse irq_in[12] -> irq_id stays 4 until ack, then 12 is presented.
- Same-cycle new edge on bit 5 while acking ID 5 -> pending[5] remains 1, ID 5 re-presented.
- TRIG_EDGE=16'h0000, hold irq_in[9]=1, mask[9]=0 -> irq_valid=0; set mask[9] -> ID 9 valid 1 cycle later; ack with line high -> re-presented; drop line -> pending[9]=0, no further valid.
